// File: rtl/fifo_rd_stream.sv
// Read-side consumer for a FIFO with one-cycle registered read data. It turns the FIFO
// into a valid/ready stream, holding up to two words.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_word_cnt;

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_slots;
  logic [2:0] w_slots_after;
  logic       w_wr_idx;
  logic       w_head_next;
  logic [1:0] w_count_next;

  assign w_pop         = m_valid && m_ready;
  assign w_push        = r_inflight;
  assign w_slots       = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_slots_after = w_slots - {2'b00, w_pop};

  // A read is issued only if its word is guaranteed a slot when it lands next cycle.
  // Gating with rst_n keeps the strobe low while the block is held in reset.
  assign fifo_rd_en = rst_n && en && !fifo_empty && (w_slots_after <= 3'd1);

  // Write slot is (head + count) mod 2. A capture never occurs when count is 2.
  assign w_wr_idx = r_head ^ r_count[0];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // On the pop that empties the buffer, the head stays put. m_data therefore keeps
  // showing the last word, and the next capture lands at the head slot.
  always_comb begin
    w_head_next = r_head;
    if (w_pop && !(r_count == 2'd1 && !w_push)) begin
      w_head_next = ~r_head;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_head     <= w_head_next;
      r_count    <= w_count_next;
      r_inflight <= fifo_rd_en;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[w_wr_idx] <= fifo_dout;
    end
  end

  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_buf[r_head];
  assign word_cnt = r_word_cnt;
  assign busy     = r_inflight || (r_count != 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream. It uses a behavioural FIFO with one-cycle read
// latency, a per-cycle stall table, and hand-written multi-cycle sequences.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;
  logic          busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .word_cnt  (word_cnt),
    .busy      (busy)
  );

  // Behavioural FIFO with registered read data
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int held = 0;
  int exp_idx = 0;
  int delivered = 0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
    logic          exp_busy;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard run at each negedge: order, stall stability, slot bound, no read while empty.
  task automatic monitor();
    logic pop;
    if (!rst_n) begin
      held = 0;
      prev_hold = 1'b0;
    end else begin
      pop = m_valid && m_ready;
      if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 0);
      chk("slots_le2", (held <= 2), 1);
      if (prev_hold) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (pop) begin
        chk("order", m_data, mem[exp_idx]);
        exp_idx++;
        delivered++;
      end
      held = held + (fifo_rd_en ? 1 : 0) - (pop ? 1 : 0);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  endtask

  task automatic sample();
    @(negedge rd_clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic resync();
    held = 0;
    delivered = 0;
    prev_hold = 1'b0;
    exp_idx = rd_ptr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
    resync();
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'h11 + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic drain(input int target, input int budget);
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < budget && delivered < target; c++) begin
      sample();
      adv();
    end
    chk("drain_count", delivered, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stall table: the FIFO holds 0x11.. and m_ready starts low
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 4'd0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 4'd1, 1'b1};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 4'd2, 1'b1};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 4'd3, 1'b1};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 4'd3, 1'b1};

    // Idle with an empty FIFO
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("idle_rd_en", fifo_rd_en, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_cnt", word_cnt, 0);
      chk("idle_busy", busy, 0);
      adv();
    end
    $display("idle phase done: %0d checks", n_checks);

    // Full throughput
    do_reset();
    load(8);
    en = 1'b1;
    m_ready = 1'b1;
    sample(); chk("thr_c0_rd", fifo_rd_en, 1); chk("thr_c0_valid", m_valid, 0); adv();
    sample(); chk("thr_c1_rd", fifo_rd_en, 1); chk("thr_c1_valid", m_valid, 0); adv();
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("thr_valid", m_valid, 1);
      chk("thr_data", m_data, 8'h11 + k);
      adv();
    end
    sample(); chk("thr_end_valid", m_valid, 0); chk("thr_cnt", word_cnt, 8); adv();
    $display("throughput phase done: delivered %0d", delivered);

    // Random back-pressure
    do_reset();
    load(8);
    en = 1'b1;
    for (int c = 0; c < 200 && delivered < 8; c++) begin
      m_ready = (c < 4) ? ((c == 0 || c == 3) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
      sample();
      adv();
    end
    chk("rand_delivered", delivered, 8);
    chk("rand_cnt", word_cnt, 8);
    $display("random ready phase done: delivered %0d", delivered);

    // Stall table
    do_reset();
    load(8);
    for (int v = 0; v < 10; v++) begin
      en = vt[v].en;
      m_ready = vt[v].rdy;
      sample();
      chk("tbl_rd_en", fifo_rd_en, vt[v].exp_rd);
      chk("tbl_valid", m_valid, vt[v].exp_valid);
      chk("tbl_data", m_data, vt[v].exp_data);
      chk("tbl_cnt", word_cnt, vt[v].exp_cnt);
      chk("tbl_busy", busy, vt[v].exp_busy);
      $display("vec %0d: rd_en=%0b valid=%0b data=%02h cnt=%0d", v, fifo_rd_en, m_valid, m_data, word_cnt);
      adv();
    end
    drain(8, 60);
    chk("tbl_final_cnt", word_cnt, 8);

    // en dropped right after one read strobe
    do_reset();
    load(8);
    en = 1'b1;
    m_ready = 1'b1;
    sample(); chk("en_c0_rd", fifo_rd_en, 1); adv();
    en = 1'b0;
    sample(); chk("en_c1_rd", fifo_rd_en, 0); chk("en_c1_valid", m_valid, 0); chk("en_c1_busy", busy, 1); adv();
    sample(); chk("en_c2_valid", m_valid, 1); chk("en_c2_data", m_data, 8'h11); chk("en_c2_rd", fifo_rd_en, 0); adv();
    sample(); chk("en_c3_valid", m_valid, 0); chk("en_c3_busy", busy, 0); adv();
    for (int c = 0; c < 3; c++) begin
      sample(); chk("en_off_rd", fifo_rd_en, 0); adv();
    end
    chk("en_cnt", word_cnt, 1);
    drain(8, 60);
    chk("en_final_cnt", word_cnt, 8);

    // Counter wrap with an 18-word stream, then reset mid-stream
    do_reset();
    load(18);
    drain(18, 80);
    chk("wrap_cnt", word_cnt, 2);
    load(8);
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      adv();
    end
    chk("pre_rst_cnt", word_cnt, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    sample();
    adv();
    rst_n = 1'b1;
    resync();
    chk("restart_head", mem[exp_idx], 8'h15);
    sample(); chk("restart_cnt", word_cnt, 0); chk("restart_rd", fifo_rd_en, 1); adv();
    drain(4, 40);
    chk("restart_final_cnt", word_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
